// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;
    localparam int          CNT_W        = 4;
endpackage

// File: rtl/fetch_lat_counter.sv
// Memory-latency down-counter: load a start value, decrement to zero, flag zero.
import fetch_pkg::*;

module fetch_lat_counter (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, waits out memory latency, presents
// the captured instruction to decode over valid/ready. FETCH_STATS_EN adds FetchCount.
import fetch_pkg::*;

module fetch_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
    parameter int                MEM_LATENCY = 1,
    parameter int                PC_STEP     = DEF_PC_STEP
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    output logic [ADDR_W-1:0]  PC,
    input  logic [INSTR_W-1:0] InstructionCode,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        FetchCount
`endif
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic              handshake, cnt_zero;
    logic              cnt_load, cnt_dec, capture;

    assign handshake = InstrValid && InstrReady;
    assign PC        = pc;

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (Run)       state_nx = S_WAIT;
            S_WAIT:  if (cnt_zero)  state_nx = S_HOLD;
            S_HOLD:  if (handshake) state_nx = Run ? S_WAIT : S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
        if (Redirect) state_nx = Run ? S_WAIT : S_IDLE;
    end

    // Reload the counter on every entry into S_WAIT, including a redirect restart.
    always_comb begin
        cnt_load = Run && (Redirect || state == S_IDLE || (state == S_HOLD && handshake));
        cnt_dec  = (state == S_WAIT) && !cnt_zero;
        capture  = (state == S_WAIT) && cnt_zero && !Redirect;
    end

    fetch_lat_counter u_lat (
        .clk      (Clk),
        .reset    (Reset),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LATENCY - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc         <= RESET_PC;
            InstrOut   <= '0;
            InstrPC    <= '0;
            InstrValid <= 1'b0;
        end else if (Redirect) begin
            pc         <= RedirectPC & ~ADDR_W'(3);
            InstrValid <= 1'b0;
        end else if (capture) begin
            InstrOut   <= InstructionCode;
            InstrPC    <= pc;
            InstrValid <= 1'b1;
            pc         <= pc + ADDR_W'(PC_STEP);
        end else if (handshake) begin
            InstrValid <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset)          FetchCount <= '0;
        else if (handshake) FetchCount <= FetchCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: L=1 instance for streaming/redirect/wrap/reset, L=3 instance for stall.
module tb_fetch_sequencer;
    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst1, run1, rdy1, rd1;
    logic [31:0] rdpc1, pc1, code1, out1, ipc1;
    logic        vld1;
    logic        rst3, run3, rdy3, rd3;
    logic [31:0] rdpc3, pc3, code3, out3, ipc3;
    logic        vld3;
`ifdef FETCH_STATS_EN
    logic [31:0] fc1, fc3;
`endif

    assign code1 = 32'hA000_0000 | pc1;
    assign code3 = 32'hA000_0000 | pc3;

    fetch_sequencer #(.MEM_LATENCY(1)) u_dut1 (
        .Clk(Clk), .Reset(rst1), .Run(run1), .PC(pc1), .InstructionCode(code1),
        .InstrOut(out1), .InstrPC(ipc1), .InstrValid(vld1), .InstrReady(rdy1),
        .Redirect(rd1), .RedirectPC(rdpc1)
`ifdef FETCH_STATS_EN
        , .FetchCount(fc1)
`endif
    );

    fetch_sequencer #(.MEM_LATENCY(3)) u_dut3 (
        .Clk(Clk), .Reset(rst3), .Run(run3), .PC(pc3), .InstructionCode(code3),
        .InstrOut(out3), .InstrPC(ipc3), .InstrValid(vld3), .InstrReady(rdy3),
        .Redirect(rd3), .RedirectPC(rdpc3)
`ifdef FETCH_STATS_EN
        , .FetchCount(fc3)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst1 = 1; run1 = 0; rdy1 = 0; rd1 = 0; rdpc1 = '0;
        rst3 = 1; run3 = 0; rdy3 = 0; rd3 = 0; rdpc3 = '0;
        tick(); tick();
        check("rst_valid", 32'(vld1), 32'd0);
        check("rst_pc", pc1, 32'h0);
        check("rst_instrpc", ipc1, 32'h0);
        check("rst_instrout", out1, 32'h0);
`ifdef FETCH_STATS_EN
        check("rst_fcount", fc1, 32'd0);
`endif

        // Streaming, L=1, decode always ready: one instruction every 2 cycles
        rst1 = 0; run1 = 1; rdy1 = 1;
        tick();
        check("start_valid", 32'(vld1), 32'd0);
        check("start_pc", pc1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stream%0d_valid", k), 32'(vld1), 32'd1);
            check($sformatf("stream%0d_ipc", k), ipc1, 32'(4 * k));
            check($sformatf("stream%0d_out", k), out1, 32'hA000_0000 | 32'(4 * k));
            check($sformatf("stream%0d_pc", k), pc1, 32'(4 * k + 4));
            tick();
            check($sformatf("stream%0d_gap", k), 32'(vld1), 32'd0);
        end

        // Redirect while waiting on the fetch of 16
        rd1 = 1; rdpc1 = 32'h0000_0103;
        tick();
        rd1 = 0;
        check("rdwait_valid", 32'(vld1), 32'd0);
        check("rdwait_pc", pc1, 32'h0000_0100);
        tick();
        check("rdwait_deliver_valid", 32'(vld1), 32'd1);
        check("rdwait_deliver_ipc", ipc1, 32'h0000_0100);
        check("rdwait_deliver_out", out1, 32'hA000_0100);

        // Get an instruction at 8 presented, then redirect on its handshake cycle
        tick();
        rd1 = 1; rdpc1 = 32'h0000_0008;
        tick();
        rd1 = 0;
        check("to8_pc", pc1, 32'h8);
        tick();
        check("at8_valid", 32'(vld1), 32'd1);
        check("at8_ipc", ipc1, 32'h8);
        rd1 = 1; rdpc1 = 32'h0000_0200;
        tick();
        rd1 = 0;
        check("hsrd_valid", 32'(vld1), 32'd0);
        check("hsrd_pc", pc1, 32'h0000_0200);
        tick();
        check("hsrd_next_valid", 32'(vld1), 32'd1);
        check("hsrd_next_ipc", ipc1, 32'h0000_0200);

        // PC wrap from the top of the address space
        rd1 = 1; rdpc1 = 32'hFFFF_FFFF;
        tick();
        rd1 = 0;
        check("wrap_rd_pc", pc1, 32'hFFFF_FFFC);
        tick();
        check("wrap_top_ipc", ipc1, 32'hFFFF_FFFC);
        check("wrap_top_pc", pc1, 32'h0);
        tick();
        tick();
        check("wrap_zero_valid", 32'(vld1), 32'd1);
        check("wrap_zero_ipc", ipc1, 32'h0);
        check("wrap_zero_out", out1, 32'hA000_0000);
`ifdef FETCH_STATS_EN
        check("fcount", fc1, 32'd8);
`endif

        // Reset while holding a valid instruction, then stay idle with Run=0
        rdy1 = 0; run1 = 0; rst1 = 1;
        tick();
        rst1 = 0;
        check("hold_rst_valid", 32'(vld1), 32'd0);
        check("hold_rst_pc", pc1, 32'h0);
        check("hold_rst_out", out1, 32'h0);
`ifdef FETCH_STATS_EN
        check("hold_rst_fcount", fc1, 32'd0);
`endif
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("idle%0d_valid", k), 32'(vld1), 32'd0);
            check($sformatf("idle%0d_pc", k), pc1, 32'h0);
        end

        // L=3 instance: decode stalls 5 cycles on the first instruction
        rst3 = 0; run3 = 1; rdy3 = 0;
        tick();
        check("l3_w0_valid", 32'(vld3), 32'd0);
        tick();
        check("l3_w1_valid", 32'(vld3), 32'd0);
        check("l3_w1_pc", pc3, 32'h0);
        tick();
        check("l3_w2_valid", 32'(vld3), 32'd0);
        tick();
        check("l3_first_valid", 32'(vld3), 32'd1);
        check("l3_first_ipc", ipc3, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("l3_stall%0d_valid", k), 32'(vld3), 32'd1);
            check($sformatf("l3_stall%0d_out", k), out3, 32'hA000_0000);
            check($sformatf("l3_stall%0d_pc", k), pc3, 32'h4);
        end
        rdy3 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("l3_refetch%0d_valid", k), 32'(vld3), 32'd0);
        end
        tick();
        check("l3_second_valid", 32'(vld3), 32'd1);
        check("l3_second_ipc", ipc3, 32'h4);
        check("l3_second_out", out3, 32'hA000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
